div_stall_unit: RTL and testbench

- Iterative radix-2 divider for DIV/DIVU in the pipelined core's execute stage.
- It is the driving end of the pipeline-register enable interface: while a division is in flight it holds `stall` high, and the core routes `stall` low into the enables of the fetch/decode/execute enable-registers.
- Results are registered and written to HI/LO by the surrounding datapath on `done`.

---
 rtl/div_stall_unit.sv | 152 +++++++++++++++
 tb/tb_div_stall_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/div_stall_unit.sv
// rtl/div_stall_unit.sv - iterative radix-2 DIV/DIVU that stalls the pipeline while busy
// Optional DIV_EARLY_OUT_EN: skip CALC when |a| < |b| and finish through FIX.
`timescale 1ns/1ps
module div_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;
  logic             accept, ge, early;

  assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign accept = (state_q == IDLE) && start && !cancel;

  // Restoring step: the dividend MSB shifts into the partial remainder.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign ge      = shifted >= {1'b0, dsr_q};

`ifdef DIV_EARLY_OUT_EN
  assign early = abs_a < abs_b;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;

    if (cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            neg_quo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = is_signed & a[WIDTH-1];
            dsr_d     = abs_b;
            rem_d     = '0;
            dvd_d     = abs_a;
            cnt_d     = '0;
            dbz_d     = 1'b0;
            if (b == '0) begin
              quo_d   = '1;
              rmd_d   = a;
              dbz_d   = 1'b1;
              state_d = DONE;
            end else if (early) begin
              rem_d   = abs_a;
              dvd_d   = '0;
              state_d = FIX;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quo_d   = neg_quo_q ? -dvd_q : dvd_q;
          rmd_d   = neg_rem_q ? -rem_q : rem_q;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      quo_q     <= '0;
      rmd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  // stall is low in DONE so the pipeline advances as the result appears.
  assign stall       = accept || (state_q == CALC) || (state_q == FIX);
  assign busy        = state_q != IDLE;
  assign done        = (state_q == DONE) && !cancel;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// tb/tb_div_stall_unit.sv - scoreboard bench for div_stall_unit
`timescale 1ns/1ps
module tb_div_stall_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         stall, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  div_stall_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .cancel(cancel), .stall(stall), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           done_seen = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dbz = 1'b0;

  always @(posedge clk) if (done) done_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference from 64-bit integer arithmetic; lat counts edges after the start edge.
  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic sgn);
    exp_t   e;
    longint sa, sbv, qq, rr, ma, mb;
    sa  = sgn ? longint'($signed(va)) : longint'(va);
    sbv = sgn ? longint'($signed(vb)) : longint'(vb);
    if (vb == '0) begin
      e.q = '1; e.r = va; e.dbz = 1'b1; e.lat = 0;
    end else begin
      qq = sa / sbv;
      rr = sa % sbv;
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
      e.dbz = 1'b0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sbv < 0) ? -sbv : sbv;
      e.lat = W + 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) e.lat = 1;
`else
      if (ma < mb) e.lat = W + 1;
`endif
    end
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic sgn,
                        input string tag, input int poke);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    check({tag, ".idle_busy"}, busy, 0);
    a = va; b = vb; is_signed = sgn; start = 1'b1;
    sb.push_back(model(va, vb, sgn));
    #1 check({tag, ".start_stall"}, stall, 1);
    @(posedge clk);
    #1 start = 1'b0; a = ~va; b = ~vb;
    lat = -1; got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (k == poke) begin start = 1'b1; a = 55; b = 2; end
      else if (k == poke + 1) start = 1'b0;
      if (done) begin got = 1; lat = k; end
      else check({tag, ".busy_stall"}, stall, 1);
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, ".done_seen"}, got, 1);
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".quotient"}, quotient, e.q);
    check({tag, ".remainder"}, remainder, e.r);
    check({tag, ".dbz"}, div_by_zero, e.dbz);
    check({tag, ".done_stall"}, stall, 0);
    last_q = e.q; last_r = e.r; last_dbz = e.dbz;
  endtask

  initial begin
    int d0;
    #12;
    check("rst.quotient", quotient, 0);
    check("rst.remainder", remainder, 0);
    check("rst.dbz", div_by_zero, 0);
    check("rst.done", done, 0);
    check("rst.busy", busy, 0);
    check("rst.stall", stall, 0);
    @(negedge clk) reset = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, "divu", 5);
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, "div_neg", -1);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf", -1);
    run_op(32'h12345678, 32'd0, 1'b0, "div0", -1);
    run_op(32'd5, 32'd9, 1'b0, "small", -1);
    run_op(32'hFFFFFFFB, 32'd9, 1'b1, "small_neg", -1);

    // Cancel mid-CALC: outputs keep the previous result, done never pulses.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = done_seen;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel.busy", busy, 0);
    check("cancel.stall", stall, 0);
    check("cancel.quotient", quotient, last_q);
    check("cancel.remainder", remainder, last_r);
    check("cancel.dbz", div_by_zero, last_dbz);
    repeat (3) @(negedge clk);
    check("cancel.no_done", done_seen, d0);

    @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
    #1 check("startcancel.stall", stall, 0);
    @(negedge clk);
    check("startcancel.busy", busy, 0);
    start = 1'b0; cancel = 1'b0;
    check("startcancel.quotient", quotient, last_q);

    // Asynchronous reset mid-CALC, checked before any clock edge.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst.quotient", quotient, 0);
    check("arst.remainder", remainder, 0);
    check("arst.dbz", div_by_zero, 0);
    check("arst.busy", busy, 0);
    check("arst.stall", stall, 0);
    check("arst.done", done, 0);
    @(negedge clk) reset = 1'b1;

    run_op(32'd9, 32'd3, 1'b0, "after_reset", -1);
    check("sb.empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
